// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared FSM state types and AXI response codes for the 2x1 AXI-Lite arbiter
package axil_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_rr_arb2.sv
// rtl/axil_rr_arb2.sv - two-requester round-robin arbiter with registered grant
module axil_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt
);

    // prio names the requester that wins a tie; it flips to the loser on every grant
    logic prio;
    logic pick;

    always_comb begin
        pick = req[prio] ? prio : ~prio;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt  <= 1'b0;
            prio <= 1'b0;
        end else if (en && (|req)) begin
            gnt  <= pick;
            prio <= ~pick;
        end
    end

endmodule

// File: rtl/axil_arb_2x1.sv
// rtl/axil_arb_2x1.sv - two-master to one-slave AXI-Lite arbiter with independent read/write paths
module axil_arb_2x1
    import axil_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic [2:0]            s0_axil_arprot,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [DATA_WIDTH-1:0] s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,

    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic [2:0]            s1_axil_arprot,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [DATA_WIDTH-1:0] s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    w_state_t   w_state, w_state_n;
    r_state_t   r_state, r_state_n;
    logic       aw_done, w_done, aw_done_n, w_done_n;
    logic       w_gnt, r_gnt;
    logic [1:0] w_req, r_req;
    logic       sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic       w_awready, w_wready, w_bvalid, r_arready, r_rvalid;
    logic       aw_hs, w_hs;

    assign w_req = {s1_axil_awvalid & s1_axil_wvalid, s0_axil_awvalid & s0_axil_wvalid};
    assign r_req = {s1_axil_arvalid, s0_axil_arvalid};

    axil_rr_arb2 u_w_arb (.clk(clk), .rst(rst), .en(w_state == W_IDLE), .req(w_req), .gnt(w_gnt));
    axil_rr_arb2 u_r_arb (.clk(clk), .rst(rst), .en(r_state == R_IDLE), .req(r_req), .gnt(r_gnt));

    assign sel_awvalid = w_gnt ? s1_axil_awvalid : s0_axil_awvalid;
    assign sel_wvalid  = w_gnt ? s1_axil_wvalid  : s0_axil_wvalid;
    assign sel_bready  = w_gnt ? s1_axil_bready  : s0_axil_bready;
    assign sel_arvalid = r_gnt ? s1_axil_arvalid : s0_axil_arvalid;
    assign sel_rready  = r_gnt ? s1_axil_rready  : s0_axil_rready;

    assign m_axil_awaddr = w_gnt ? s1_axil_awaddr : s0_axil_awaddr;
    assign m_axil_awprot = w_gnt ? s1_axil_awprot : s0_axil_awprot;
    assign m_axil_wdata  = w_gnt ? s1_axil_wdata  : s0_axil_wdata;
    assign m_axil_wstrb  = w_gnt ? s1_axil_wstrb  : s0_axil_wstrb;
    assign m_axil_araddr = r_gnt ? s1_axil_araddr : s0_axil_araddr;
    assign m_axil_arprot = r_gnt ? s1_axil_arprot : s0_axil_arprot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // AW and W complete independently; each channel's valid is masked once it has handshaken
    always_comb begin
        w_state_n      = w_state;
        aw_done_n      = aw_done;
        w_done_n       = w_done;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        w_awready      = 1'b0;
        w_wready       = 1'b0;
        w_bvalid       = 1'b0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (|w_req) w_state_n = W_ADDR;
            end
            W_ADDR: begin
                m_axil_awvalid = sel_awvalid & ~aw_done;
                m_axil_wvalid  = sel_wvalid & ~w_done;
                w_awready      = m_axil_awready & ~aw_done;
                w_wready       = m_axil_wready & ~w_done;
                aw_hs          = sel_awvalid & ~aw_done & m_axil_awready;
                w_hs           = sel_wvalid & ~w_done & m_axil_wready;
                aw_done_n      = aw_done | aw_hs;
                w_done_n       = w_done | w_hs;
                if (aw_done_n && w_done_n) begin
                    w_state_n = W_RESP;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            W_RESP: begin
                w_bvalid      = m_axil_bvalid;
                m_axil_bready = sel_bready;
                if (m_axil_bvalid && sel_bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_n      = r_state;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        r_arready      = 1'b0;
        r_rvalid       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (|r_req) r_state_n = R_ADDR;
            end
            R_ADDR: begin
                m_axil_arvalid = sel_arvalid;
                r_arready      = m_axil_arready;
                if (sel_arvalid && m_axil_arready) r_state_n = R_RESP;
            end
            R_RESP: begin
                r_rvalid      = m_axil_rvalid;
                m_axil_rready = sel_rready;
                if (m_axil_rvalid && sel_rready) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    assign s0_axil_awready = w_awready & ~w_gnt;
    assign s1_axil_awready = w_awready &  w_gnt;
    assign s0_axil_wready  = w_wready  & ~w_gnt;
    assign s1_axil_wready  = w_wready  &  w_gnt;
    assign s0_axil_bvalid  = w_bvalid  & ~w_gnt;
    assign s1_axil_bvalid  = w_bvalid  &  w_gnt;
    assign s0_axil_arready = r_arready & ~r_gnt;
    assign s1_axil_arready = r_arready &  r_gnt;
    assign s0_axil_rvalid  = r_rvalid  & ~r_gnt;
    assign s1_axil_rvalid  = r_rvalid  &  r_gnt;

    // Response payloads fan out to both masters; only the valid is steered
    assign s0_axil_bresp = m_axil_bresp;
    assign s1_axil_bresp = m_axil_bresp;
    assign s0_axil_rresp = m_axil_rresp;
    assign s1_axil_rresp = m_axil_rresp;
    assign s0_axil_rdata = m_axil_rdata;
    assign s1_axil_rdata = m_axil_rdata;

endmodule
